// File: rtl/gpr_mp.sv
// Multi-port GPR file: RD_PORTS combinational read ports, two byte-enabled write
// ports (port 1 wins), write-through bypass, optional zero register, busy scoreboard.

module gpr_mp_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic [DATA_W-1:0]   stored_i,
    input  logic                busy_i,
    input  logic                wr0_en_i,
    input  logic [ADDR_W-1:0]   wr0_addr_i,
    input  logic [DATA_W/8-1:0] wr0_be_i,
    input  logic [DATA_W-1:0]   wr0_data_i,
    input  logic                wr1_en_i,
    input  logic [ADDR_W-1:0]   wr1_addr_i,
    input  logic [DATA_W/8-1:0] wr1_be_i,
    input  logic [DATA_W-1:0]   wr1_data_i,
    input  logic                clr0_en_i,
    input  logic                clr1_en_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_busy_o
);
    localparam int NB = DATA_W / 8;

    logic hit0, hit1, is_zero;

    assign hit0    = wr0_en_i && (wr0_addr_i == rd_addr_i);
    assign hit1    = wr1_en_i && (wr1_addr_i == rd_addr_i);
    assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

    always_comb begin
        rd_data_o = stored_i;
        if (BYPASS != 0) begin
            for (int b = 0; b < NB; b++) begin
                if (hit1 && wr1_be_i[b])
                    rd_data_o[b*8 +: 8] = wr1_data_i[b*8 +: 8];
                else if (hit0 && wr0_be_i[b])
                    rd_data_o[b*8 +: 8] = wr0_data_i[b*8 +: 8];
            end
        end
        if (is_zero)
            rd_data_o = '0;
    end

    // A clear landing this cycle already frees the operand for the reader.
    assign rd_busy_o = busy_i && !is_zero
                     && !(clr0_en_i && (wr0_addr_i == rd_addr_i))
                     && !(clr1_en_i && (wr1_addr_i == rd_addr_i));
endmodule

module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
    output logic [RD_PORTS-1:0]          rd_busy_o,
    input  logic                         we0_ni,
    input  logic [ADDR_W-1:0]            wr0_addr_i,
    input  logic [DATA_W/8-1:0]          wr0_be_i,
    input  logic [DATA_W-1:0]            wr0_data_i,
    input  logic                         we1_ni,
    input  logic [ADDR_W-1:0]            wr1_addr_i,
    input  logic [DATA_W/8-1:0]          wr1_be_i,
    input  logic [DATA_W-1:0]            wr1_data_i,
    input  logic                         issue_ni,
    input  logic [ADDR_W-1:0]            issue_addr_i,
    input  logic                         clr0_ni,
    input  logic                         clr1_ni,
    output logic [(1<<ADDR_W)-1:0]       busy_vec_o
);
    localparam int NB       = DATA_W / 8;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit ZR       = (ZERO_REG != 0);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic wr0_en, wr1_en, clr0_en, clr1_en, issue_en;

    // Gating with rst_ni keeps the bypass path quiet while reset is held.
    assign wr0_en   = rst_ni && !we0_ni   && !(ZR && (wr0_addr_i == '0));
    assign wr1_en   = rst_ni && !we1_ni   && !(ZR && (wr1_addr_i == '0));
    assign issue_en = rst_ni && !issue_ni && !(ZR && (issue_addr_i == '0));
    assign clr0_en  = rst_ni && !clr0_ni;
    assign clr1_en  = rst_ni && !clr1_ni;

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr1_en && (wr1_addr_i == ADDR_W'(r)) && wr1_be_i[b])
                    regs_d[r][b*8 +: 8] = wr1_data_i[b*8 +: 8];
                else if (wr0_en && (wr0_addr_i == ADDR_W'(r)) && wr0_be_i[b])
                    regs_d[r][b*8 +: 8] = wr0_data_i[b*8 +: 8];
            end
        end
    end

    // Clears first, then issue, so a new producer on the same register stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (clr0_en)  busy_d[wr0_addr_i]   = 1'b0;
        if (clr1_en)  busy_d[wr1_addr_i]   = 1'b0;
        if (issue_en) busy_d[issue_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        gpr_mp_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rd_addr_i (addr),
            .stored_i  (regs_q[addr]),
            .busy_i    (busy_q[addr]),
            .wr0_en_i  (wr0_en),
            .wr0_addr_i(wr0_addr_i),
            .wr0_be_i  (wr0_be_i),
            .wr0_data_i(wr0_data_i),
            .wr1_en_i  (wr1_en),
            .wr1_addr_i(wr1_addr_i),
            .wr1_be_i  (wr1_be_i),
            .wr1_data_i(wr1_data_i),
            .clr0_en_i (clr0_en),
            .clr1_en_i (clr1_en),
            .rd_data_o (rd_data_o[k*DATA_W +: DATA_W]),
            .rd_busy_o (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: three instances (bypass, no-bypass, zero-register)
// share one stimulus stream; each scenario task checks its own expectations.

module tb_gpr_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        we0_n, we1_n, issue_n, clr0_n, clr1_n;
    logic [4:0]  wr0_addr, wr1_addr, issue_addr;
    logic [3:0]  wr0_be, wr1_be;
    logic [31:0] wr0_data, wr1_data;

    logic [63:0] rd_b, rd_nb, rd_z;
    logic [1:0]  bsy_b, bsy_nb, bsy_z;
    logic [31:0] vec_b, vec_nb, vec_z;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpr_mp #(.RD_PORTS(2), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_b), .rd_busy_o(bsy_b),
        .we0_ni(we0_n), .wr0_addr_i(wr0_addr), .wr0_be_i(wr0_be), .wr0_data_i(wr0_data),
        .we1_ni(we1_n), .wr1_addr_i(wr1_addr), .wr1_be_i(wr1_be), .wr1_data_i(wr1_data),
        .issue_ni(issue_n), .issue_addr_i(issue_addr), .clr0_ni(clr0_n), .clr1_ni(clr1_n),
        .busy_vec_o(vec_b));

    gpr_mp #(.RD_PORTS(2), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_nb), .rd_busy_o(bsy_nb),
        .we0_ni(we0_n), .wr0_addr_i(wr0_addr), .wr0_be_i(wr0_be), .wr0_data_i(wr0_data),
        .we1_ni(we1_n), .wr1_addr_i(wr1_addr), .wr1_be_i(wr1_be), .wr1_data_i(wr1_data),
        .issue_ni(issue_n), .issue_addr_i(issue_addr), .clr0_ni(clr0_n), .clr1_ni(clr1_n),
        .busy_vec_o(vec_nb));

    gpr_mp #(.RD_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_z), .rd_busy_o(bsy_z),
        .we0_ni(we0_n), .wr0_addr_i(wr0_addr), .wr0_be_i(wr0_be), .wr0_data_i(wr0_data),
        .we1_ni(we1_n), .wr1_addr_i(wr1_addr), .wr1_be_i(wr1_be), .wr1_data_i(wr1_data),
        .issue_ni(issue_n), .issue_addr_i(issue_addr), .clr0_ni(clr0_n), .clr1_ni(clr1_n),
        .busy_vec_o(vec_z));

    task automatic idle();
        we0_n = 1'b1; we1_n = 1'b1; issue_n = 1'b1; clr0_n = 1'b1; clr1_n = 1'b1;
        wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
        wr0_be = '0; wr1_be = '0; wr0_data = '0; wr1_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (rd_b !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h exp 0", rd_b); end
        n_chk++; if (vec_b !== 32'h0) begin n_fail++; $display("FAIL reset_busy_vec: got %h exp 0", vec_b); end
        @(negedge clk); rst_n = 1'b1;
        step();
        we0_n = 1'b0; wr0_addr = 5'd5; wr0_be = 4'hF; wr0_data = 32'h12345678;
        issue_n = 1'b0; issue_addr = 5'd5; rd_addr = {5'd5, 5'd5};
        step(); idle();
        #1;
        n_chk++; if (rd_nb[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL r5_written: got %h exp 12345678", rd_nb[31:0]); end
        n_chk++; if (vec_b !== 32'h20) begin n_fail++; $display("FAIL r5_busy: got %h exp 00000020", vec_b); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (rd_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL midreset_rd_data: got %h exp 0", rd_b[31:0]); end
        n_chk++; if (vec_b !== 32'h0) begin n_fail++; $display("FAIL midreset_busy_vec: got %h exp 0", vec_b); end
        n_chk++; if (bsy_b !== 2'b00) begin n_fail++; $display("FAIL midreset_rd_busy: got %b exp 00", bsy_b); end
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        rd_addr = {5'd0, 5'd3};
        we0_n = 1'b0; wr0_addr = 5'd3; wr0_be = 4'hF; wr0_data = 32'hDEADBEEF;
        #1;
        n_chk++; if (rd_b[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h exp deadbeef", rd_b[31:0]); end
        n_chk++; if (rd_nb[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h exp 0", rd_nb[31:0]); end
        step(); idle();
        #1;
        n_chk++; if (rd_nb[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle: got %h exp deadbeef", rd_nb[31:0]); end
        we1_n = 1'b0; wr1_addr = 5'd3; wr1_be = 4'b0011; wr1_data = 32'hCAFEF00D;
        #1;
        n_chk++; if (rd_b[31:0] !== 32'hDEADF00D) begin n_fail++; $display("FAIL bypass_p1_partial: got %h exp deadf00d", rd_b[31:0]); end
        n_chk++; if (rd_nb[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_p1_old: got %h exp deadbeef", rd_nb[31:0]); end
        step(); idle();
        #1;
        n_chk++; if (rd_nb[31:0] !== 32'hDEADF00D) begin n_fail++; $display("FAIL p1_partial_stored: got %h exp deadf00d", rd_nb[31:0]); end
    endtask

    task automatic test_byte_dual();
        rd_addr = {5'd0, 5'd7};
        we0_n = 1'b0; wr0_addr = 5'd7; wr0_be = 4'hF;    wr0_data = 32'h11223344;
        we1_n = 1'b0; wr1_addr = 5'd7; wr1_be = 4'b0101; wr1_data = 32'hAABBCCDD;
        #1;
        n_chk++; if (rd_b[31:0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL dual_bypass: got %h exp 11bb33dd", rd_b[31:0]); end
        step(); idle();
        #1;
        n_chk++; if (rd_nb[31:0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL dual_stored: got %h exp 11bb33dd", rd_nb[31:0]); end
        we0_n = 1'b0; wr0_addr = 5'd7; wr0_be = 4'b1000; wr0_data = 32'hFFFFFFFF;
        #1;
        n_chk++; if (rd_b[31:0] !== 32'hFFBB33DD) begin n_fail++; $display("FAIL be_bypass: got %h exp ffbb33dd", rd_b[31:0]); end
        step(); idle();
        #1;
        n_chk++; if (rd_nb[31:0] !== 32'hFFBB33DD) begin n_fail++; $display("FAIL be_stored: got %h exp ffbb33dd", rd_nb[31:0]); end
        rd_addr = {5'd13, 5'd12};
        we0_n = 1'b0; wr0_addr = 5'd12; wr0_be = 4'hF; wr0_data = 32'h0000AAAA;
        we1_n = 1'b0; wr1_addr = 5'd13; wr1_be = 4'hF; wr1_data = 32'h00005555;
        #1;
        n_chk++; if (rd_b[63:32] !== 32'h00005555) begin n_fail++; $display("FAIL rdport1_bypass: got %h exp 00005555", rd_b[63:32]); end
        step(); idle();
        #1;
        n_chk++; if (rd_nb !== 64'h00005555_0000AAAA) begin n_fail++; $display("FAIL split_addr_stored: got %h exp 000055550000aaaa", rd_nb); end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd9, 5'd9};
        issue_n = 1'b0; issue_addr = 5'd9;
        #1;
        n_chk++; if (bsy_b !== 2'b00) begin n_fail++; $display("FAIL issue_same_cycle: got %b exp 00", bsy_b); end
        step(); idle();
        #1;
        n_chk++; if (vec_b !== 32'h200) begin n_fail++; $display("FAIL issue_busy_vec: got %h exp 00000200", vec_b); end
        n_chk++; if (bsy_b !== 2'b11) begin n_fail++; $display("FAIL issue_rd_busy: got %b exp 11", bsy_b); end
        clr1_n = 1'b0; wr1_addr = 5'd9;
        #1;
        n_chk++; if (bsy_b !== 2'b00) begin n_fail++; $display("FAIL clr1_same_cycle: got %b exp 00", bsy_b); end
        n_chk++; if (vec_b !== 32'h200) begin n_fail++; $display("FAIL clr1_vec_before_edge: got %h exp 00000200", vec_b); end
        step(); idle();
        #1;
        n_chk++; if (vec_b !== 32'h0) begin n_fail++; $display("FAIL clr1_vec_after: got %h exp 0", vec_b); end
        issue_n = 1'b0; issue_addr = 5'd9;
        step(); idle();
        clr0_n = 1'b0; wr0_addr = 5'd9; issue_n = 1'b0; issue_addr = 5'd9;
        #1;
        n_chk++; if (bsy_b !== 2'b00) begin n_fail++; $display("FAIL clr0_same_cycle: got %b exp 00", bsy_b); end
        step(); idle();
        #1;
        n_chk++; if (vec_b !== 32'h200) begin n_fail++; $display("FAIL issue_wins_clear: got %h exp 00000200", vec_b); end
        clr0_n = 1'b0; wr0_addr = 5'd10;
        #1;
        n_chk++; if (bsy_b !== 2'b11) begin n_fail++; $display("FAIL clr_other_rd_busy: got %b exp 11", bsy_b); end
        step(); idle();
        #1;
        n_chk++; if (vec_b !== 32'h200) begin n_fail++; $display("FAIL clr_nonbusy: got %h exp 00000200", vec_b); end
    endtask

    task automatic test_zero();
        rd_addr = {5'd7, 5'd0};
        we0_n = 1'b0; wr0_addr = 5'd0; wr0_be = 4'hF; wr0_data = 32'hFFFFFFFF;
        issue_n = 1'b0; issue_addr = 5'd0;
        #1;
        n_chk++; if (rd_z[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h exp 0", rd_z[31:0]); end
        n_chk++; if (rd_b[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL r0_plain_bypass: got %h exp ffffffff", rd_b[31:0]); end
        step(); idle();
        #1;
        n_chk++; if (rd_z[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_stored: got %h exp 0", rd_z[31:0]); end
        n_chk++; if (bsy_z[0] !== 1'b0) begin n_fail++; $display("FAIL zero_rd_busy: got %b exp 0", bsy_z[0]); end
        n_chk++; if (vec_z[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy_vec: got %b exp 0", vec_z[0]); end
        n_chk++; if (vec_b[0] !== 1'b1) begin n_fail++; $display("FAIL r0_plain_busy: got %b exp 1", vec_b[0]); end
        n_chk++; if (rd_z[63:32] !== 32'hFFBB33DD) begin n_fail++; $display("FAIL zero_other_reg: got %h exp ffbb33dd", rd_z[63:32]); end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        test_reset();
        test_bypass();
        test_byte_dual();
        test_scoreboard();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
